// File: rtl/clps_pkg.sv
// Shared types and constants for the CLPS pad-pair link controller:
// state encoding, configuration word layout and reset configuration.
package clps_pkg;

  typedef enum logic [3:0] {
    ST_OFF, ST_TERM, ST_RXON, ST_TXON, ST_ACTIVE,
    ST_MUTE_PRE, ST_APPLY, ST_MUTE_POST, ST_DOWN
  } clps_state_e;

  // Pad-control bundle that is decoded from the state and then registered.
  typedef struct packed {
    logic tx_en;
    logic rx_en;
    logic term_en;
    logic set_cm;
    logic data_in;
    logic link_up;
    logic busy;
  } clps_pad_t;

  localparam int CFG_W         = 15;
  localparam int CFG_DRV_OFS   = 12;
  localparam int CFG_DRV_W     = 3;
  localparam int CFG_PEMODE_OFS = 10;
  localparam int CFG_PEMODE_W  = 2;
  localparam int CFG_PESTR_OFS = 7;
  localparam int CFG_PESTR_W   = 3;
  localparam int CFG_PEWID_OFS = 4;
  localparam int CFG_PEWID_W   = 3;
  localparam int CFG_TXINV_OFS = 3;
  localparam int CFG_RXINV_OFS = 2;
  localparam int CFG_EQ_OFS    = 0;
  localparam int CFG_EQ_W      = 2;

  localparam logic [CFG_W-1:0] CLPS_CFG_RST = 15'h4000;

  // Width of a down-counter able to hold the largest of the wait lengths.
  function automatic int clps_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clps_link_ctrl_if.sv
// Control-side bundle between the chip register logic and clps_link_ctrl.
// The master is the register logic; the link controller is the slave.
interface clps_link_ctrl_if;
  import clps_pkg::*;

  logic             start;
  logic             stop;
  logic             cfg_wr;
  logic [CFG_W-1:0] cfg_wdata;
  logic             cfg_ready;
  logic             tx_data;
  logic             link_up;
  logic             busy;

  modport master (
    output start, stop, cfg_wr, cfg_wdata, tx_data,
    input  cfg_ready, link_up, busy
  );

  modport slave (
    input  start, stop, cfg_wr, cfg_wdata, tx_data,
    output cfg_ready, link_up, busy
  );
endinterface

// File: rtl/clps_wait_cnt.sv
// Loadable down-counter that saturates at 0 and flags when it is there.
module clps_wait_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/clps_link_ctrl.sv
// CLPS pad-pair power-up sequencer and muted configuration scheduler.
// Optional boost pulse generation is built only when CLPS_BOOST_EN is defined.
module clps_link_ctrl
  import clps_pkg::*;
#(
  parameter int TERM_WAIT    = 16,
  parameter int RX_WAIT      = 32,
  parameter int GUARD        = 4,
  parameter int BOOST_CYCLES = 8
) (
  input  logic                 DCLK_1,
  input  logic                 rst,
  clps_link_ctrl_if.slave      ctl,
  output logic                 DataIn,
  output logic                 TxEn,
  output logic                 RxEn,
  output logic                 termEn,
  output logic                 setCM,
  output logic                 boost,
  output logic [CFG_DRV_W-1:0]    DrvStrength,
  output logic [CFG_PEMODE_W-1:0] PEmode,
  output logic [CFG_PESTR_W-1:0]  PEstrength,
  output logic [CFG_PEWID_W-1:0]  PEwidth,
  output logic                 TxInvert,
  output logic                 RxInvert,
  output logic [CFG_EQ_W-1:0]  equalizer
);
  localparam int CW = clps_cnt_w(TERM_WAIT, RX_WAIT, GUARD, BOOST_CYCLES);

  clps_state_e      state_q, state_d;
  logic             wait_load, wait_zero;
  logic [CW-1:0]    wait_val;
  logic [1:0]       down_ph_q;
  logic [CFG_W-1:0] shadow_q, applied_q;
  clps_pad_t        pad_d, pad_q;
  logic             ready_d, ready_q;
  logic             enter_down;

  clps_wait_cnt #(.W(CW)) u_wait_cnt (
    .clk(DCLK_1), .rst(rst), .load(wait_load), .load_val(wait_val), .zero(wait_zero)
  );

  always_ff @(posedge DCLK_1) begin
    if (rst) state_q <= ST_OFF;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    wait_load = 1'b0;
    wait_val  = '0;
    if (ctl.stop && state_q != ST_OFF && state_q != ST_DOWN) begin
      state_d = ST_DOWN;
    end else begin
      case (state_q)
        ST_OFF: if (ctl.start && !ctl.stop) begin
          state_d = ST_TERM; wait_load = 1'b1; wait_val = CW'(TERM_WAIT - 1);
        end
        ST_TERM: if (wait_zero) begin
          state_d = ST_RXON; wait_load = 1'b1; wait_val = CW'(RX_WAIT - 1);
        end
        ST_RXON:   if (wait_zero) state_d = ST_TXON;
        ST_TXON:   state_d = ST_ACTIVE;
        ST_ACTIVE: if (ctl.cfg_wr) begin
          state_d = ST_MUTE_PRE; wait_load = 1'b1; wait_val = CW'(GUARD - 1);
        end
        ST_MUTE_PRE: if (wait_zero) state_d = ST_APPLY;
        ST_APPLY: begin
          state_d = ST_MUTE_POST; wait_load = 1'b1; wait_val = CW'(GUARD - 1);
        end
        ST_MUTE_POST: if (wait_zero) state_d = ST_ACTIVE;
        ST_DOWN:      if (down_ph_q == 2'd2) state_d = ST_OFF;
        default:      state_d = ST_OFF;
      endcase
    end
  end

  assign enter_down = (state_d == ST_DOWN) && (state_q != ST_DOWN);

  always_ff @(posedge DCLK_1) begin
    if (rst || state_d != ST_DOWN || state_q != ST_DOWN) down_ph_q <= 2'd0;
    else                                                  down_ph_q <= down_ph_q + 2'd1;
  end

  // Pad controls follow the current state one register stage later;
  // cfg_ready instead tracks the state being entered so it drops on acceptance.
  always_comb begin
    pad_d   = '0;
    ready_d = (state_d == ST_OFF) || (state_d == ST_ACTIVE);
    case (state_q)
      ST_TERM: begin
        pad_d.term_en = 1'b1; pad_d.set_cm = 1'b1; pad_d.busy = 1'b1;
      end
      ST_RXON: begin
        pad_d.term_en = 1'b1; pad_d.set_cm = 1'b1; pad_d.rx_en = 1'b1; pad_d.busy = 1'b1;
      end
      ST_TXON, ST_MUTE_PRE, ST_APPLY, ST_MUTE_POST: begin
        pad_d.term_en = 1'b1; pad_d.set_cm = 1'b1; pad_d.rx_en = 1'b1;
        pad_d.tx_en = 1'b1; pad_d.busy = 1'b1;
      end
      ST_ACTIVE: begin
        pad_d.term_en = 1'b1; pad_d.set_cm = 1'b1; pad_d.rx_en = 1'b1;
        pad_d.tx_en = 1'b1; pad_d.link_up = 1'b1; pad_d.data_in = ctl.tx_data;
      end
      ST_DOWN: begin
        pad_d.rx_en   = (down_ph_q == 2'd0);
        pad_d.term_en = (down_ph_q != 2'd2);
        pad_d.set_cm  = (down_ph_q != 2'd2);
        pad_d.busy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge DCLK_1) begin
    if (rst) begin
      pad_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      pad_q   <= pad_d;
      ready_q <= ready_d;
    end
  end

  // Going down abandons any pending shadow write and skips an in-flight apply.
  always_ff @(posedge DCLK_1) begin
    if (rst) begin
      shadow_q  <= CLPS_CFG_RST;
      applied_q <= CLPS_CFG_RST;
    end else if (enter_down) begin
      shadow_q <= applied_q;
    end else begin
      case (state_q)
        ST_OFF: if (ctl.cfg_wr) begin
          shadow_q  <= ctl.cfg_wdata;
          applied_q <= ctl.cfg_wdata;
        end
        ST_ACTIVE: if (ctl.cfg_wr) shadow_q <= ctl.cfg_wdata;
        ST_APPLY:  applied_q <= shadow_q;
        default: ;
      endcase
    end
  end

`ifdef CLPS_BOOST_EN
  logic boost_load, boost_zero, boost_q;

  assign boost_load = ((state_q == ST_TXON) || (state_q == ST_APPLY)) && !enter_down;

  clps_wait_cnt #(.W(CW)) u_boost_cnt (
    .clk(DCLK_1), .rst(rst), .load(boost_load),
    .load_val(CW'(BOOST_CYCLES - 1)), .zero(boost_zero)
  );

  always_ff @(posedge DCLK_1) begin
    if (rst || state_q == ST_DOWN) boost_q <= 1'b0;
    else if (boost_load)           boost_q <= 1'b1;
    else if (boost_zero)           boost_q <= 1'b0;
  end

  assign boost = boost_q;
`else
  assign boost = 1'b0;
`endif

  assign ctl.cfg_ready = ready_q;
  assign ctl.link_up   = pad_q.link_up;
  assign ctl.busy      = pad_q.busy;
  assign DataIn        = pad_q.data_in;
  assign TxEn          = pad_q.tx_en;
  assign RxEn          = pad_q.rx_en;
  assign termEn        = pad_q.term_en;
  assign setCM         = pad_q.set_cm;

  assign DrvStrength = applied_q[CFG_DRV_OFS   +: CFG_DRV_W];
  assign PEmode      = applied_q[CFG_PEMODE_OFS +: CFG_PEMODE_W];
  assign PEstrength  = applied_q[CFG_PESTR_OFS +: CFG_PESTR_W];
  assign PEwidth     = applied_q[CFG_PEWID_OFS +: CFG_PEWID_W];
  assign TxInvert    = applied_q[CFG_TXINV_OFS];
  assign RxInvert    = applied_q[CFG_RXINV_OFS];
  assign equalizer   = applied_q[CFG_EQ_OFS    +: CFG_EQ_W];
endmodule

// File: tb/tb_clps_link_ctrl.sv
// Directed scoreboard bench for clps_link_ctrl: expectations are queued with
// the cycle they fall due and compared at the falling edge of that cycle.
module tb_clps_link_ctrl;
  import clps_pkg::*;

  localparam int B_TX = 15, B_RX = 16, B_TERM = 17, B_CM = 18, B_DATA = 19;
  localparam int B_LINK = 20, B_BUSY = 21, B_RDY = 22, B_BOOST = 23;
  localparam logic [23:0] FULL    = 24'hFFFFFF;
  localparam logic [23:0] RST_VEC = 24'h404000;

  typedef struct {
    int          at;
    string       tag;
    logic [23:0] mask;
    logic [23:0] val;
  } exp_t;

  logic DCLK_1 = 1'b0;
  logic rst;
  logic DataIn, TxEn, RxEn, termEn, setCM, boost;
  logic [2:0] DrvStrength;
  logic [1:0] PEmode;
  logic [2:0] PEstrength;
  logic [2:0] PEwidth;
  logic TxInvert, RxInvert;
  logic [1:0] equalizer;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  clps_link_ctrl_if ctl();

  clps_link_ctrl #(
    .TERM_WAIT(16), .RX_WAIT(32), .GUARD(4), .BOOST_CYCLES(8)
  ) dut (
    .DCLK_1(DCLK_1), .rst(rst), .ctl(ctl),
    .DataIn(DataIn), .TxEn(TxEn), .RxEn(RxEn), .termEn(termEn), .setCM(setCM),
    .boost(boost), .DrvStrength(DrvStrength), .PEmode(PEmode),
    .PEstrength(PEstrength), .PEwidth(PEwidth), .TxInvert(TxInvert),
    .RxInvert(RxInvert), .equalizer(equalizer)
  );

  initial forever #5 DCLK_1 = ~DCLK_1;

  always @(posedge DCLK_1) cyc <= cyc + 1;

  function automatic logic [23:0] sample();
    return {boost, ctl.cfg_ready, ctl.busy, ctl.link_up, DataIn, setCM, termEn, RxEn, TxEn,
            DrvStrength, PEmode, PEstrength, PEwidth, TxInvert, RxInvert, equalizer};
  endfunction

  task automatic push(input int at, input string tag, input logic [23:0] mask,
                      input logic [23:0] val);
    exp_t e;
    int   i;
    e.at = at; e.tag = tag; e.mask = mask; e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_bit(input int at, input string tag, input int b, input logic v);
    logic [23:0] one;
    one = 24'd1;
    push(at, tag, one << b, {23'd0, v} << b);
  endtask

  task automatic exp_cfg(input int at, input string tag, input logic [14:0] v);
    push(at, tag, 24'h007FFF, {9'd0, v});
  endtask

  task automatic tick();
    exp_t        e;
    logic [23:0] obs;
    @(posedge DCLK_1);
    @(negedge DCLK_1);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e   = sb.pop_front();
      obs = sample() & e.mask;
      n_cmp++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s @cycle %0d: observed %h expected %h", e.tag, cyc, obs, e.val);
      end
    end
  endtask

  task automatic goto(input int at);
    while (cyc < at) tick();
  endtask

  initial begin
    int c, e0, w0, s0;
    rst = 1'b1;
    ctl.start = 1'b0; ctl.stop = 1'b0; ctl.cfg_wr = 1'b0;
    ctl.cfg_wdata = '0; ctl.tx_data = 1'b0;

    // Reset state
    push(2, "reset", FULL, RST_VEC);
    tick(); tick();
    rst = 1'b0;

    // Write in OFF lands directly in the applied configuration
    c = cyc;
    ctl.cfg_wr = 1'b1; ctl.cfg_wdata = 15'h1234;
    exp_cfg(c + 1, "off_write", 15'h1234);
    exp_bit(c + 1, "off_ready", B_RDY, 1'b1);
    tick();
    ctl.cfg_wr = 1'b0;

    // Bring-up timing
    c = cyc; e0 = c + 1;
    ctl.start = 1'b1;
    exp_bit(e0,      "term_early",  B_TERM, 1'b0);
    exp_bit(e0,      "ready_drop",  B_RDY,  1'b0);
    exp_bit(e0 + 1,  "term_on",     B_TERM, 1'b1);
    exp_bit(e0 + 1,  "cm_on",       B_CM,   1'b1);
    exp_bit(e0 + 1,  "busy_on",     B_BUSY, 1'b1);
    exp_bit(e0 + 16, "rx_early",    B_RX,   1'b0);
    exp_bit(e0 + 17, "rx_on",       B_RX,   1'b1);
    exp_bit(e0 + 48, "tx_early",    B_TX,   1'b0);
    exp_bit(e0 + 48, "ready_lo",    B_RDY,  1'b0);
    exp_bit(e0 + 49, "tx_on",       B_TX,   1'b1);
    exp_bit(e0 + 49, "ready_back",  B_RDY,  1'b1);
    exp_bit(e0 + 49, "link_early",  B_LINK, 1'b0);
    exp_bit(e0 + 49, "busy_last",   B_BUSY, 1'b1);
    exp_bit(e0 + 50, "link_on",     B_LINK, 1'b1);
    exp_bit(e0 + 50, "busy_off",    B_BUSY, 1'b0);
`ifdef CLPS_BOOST_EN
    exp_bit(e0 + 48, "boost_pre",   B_BOOST, 1'b0);
    exp_bit(e0 + 49, "boost_first", B_BOOST, 1'b1);
    exp_bit(e0 + 56, "boost_last",  B_BOOST, 1'b1);
    exp_bit(e0 + 57, "boost_end",   B_BOOST, 1'b0);
`else
    exp_bit(e0 + 49, "boost_tied",  B_BOOST, 1'b0);
    exp_bit(e0 + 52, "boost_tied2", B_BOOST, 1'b0);
`endif
    tick();
    ctl.start = 1'b0;
    goto(e0 + 58);

    // DataIn follows tx_data one cycle later
    c = cyc;
    ctl.tx_data = 1'b1;
    exp_bit(c + 1, "data_hi", B_DATA, 1'b1);
    tick();
    ctl.tx_data = 1'b0;
    exp_bit(c + 2, "data_lo", B_DATA, 1'b0);
    tick(); tick();

    // Muted apply of 15'h7FFF with a dropped second write during MUTE_PRE
    c = cyc; w0 = c + 1;
    ctl.tx_data = 1'b1; ctl.cfg_wr = 1'b1; ctl.cfg_wdata = 15'h7FFF;
    exp_bit(w0, "mute_data_pre", B_DATA, 1'b1);
    for (int k = 1; k <= 9; k++) exp_bit(w0 + k, "mute_data", B_DATA, 1'b0);
    exp_bit(w0 + 10, "mute_data_back", B_DATA, 1'b1);
    exp_bit(w0,      "mute_ready_lo",  B_RDY,  1'b0);
    exp_bit(w0 + 8,  "mute_ready_hold", B_RDY, 1'b0);
    exp_bit(w0 + 9,  "mute_ready_back", B_RDY, 1'b1);
    exp_bit(w0 + 1,  "mute_link_lo",   B_LINK, 1'b0);
    exp_bit(w0 + 9,  "mute_link_hold", B_LINK, 1'b0);
    exp_bit(w0 + 10, "mute_link_back", B_LINK, 1'b1);
    exp_cfg(w0 + 4,  "cfg_old",  15'h1234);
    exp_cfg(w0 + 5,  "cfg_max",  15'h7FFF);
    exp_cfg(w0 + 12, "cfg_kept", 15'h7FFF);
`ifdef CLPS_BOOST_EN
    exp_bit(w0 + 4,  "aboost_pre",   B_BOOST, 1'b0);
    exp_bit(w0 + 5,  "aboost_first", B_BOOST, 1'b1);
    exp_bit(w0 + 12, "aboost_last",  B_BOOST, 1'b1);
    exp_bit(w0 + 13, "aboost_end",   B_BOOST, 1'b0);
`else
    exp_bit(w0 + 6,  "aboost_tied",  B_BOOST, 1'b0);
`endif
    tick();
    ctl.cfg_wr = 1'b0;
    tick();
    ctl.cfg_wr = 1'b1; ctl.cfg_wdata = 15'h0AAA;
    tick();
    ctl.cfg_wr = 1'b0;
    goto(w0 + 14);

    // stop during MUTE_PRE: ordered power-down, applied config untouched
    c = cyc; w0 = c + 1;
    ctl.cfg_wr = 1'b1; ctl.cfg_wdata = 15'h0123;
    tick();
    ctl.cfg_wr = 1'b0; ctl.stop = 1'b1;
    s0 = w0 + 1;
    exp_bit(s0,     "down_tx_hold",   B_TX,   1'b1);
    exp_bit(s0 + 1, "down_tx_off",    B_TX,   1'b0);
    exp_bit(s0 + 1, "down_rx_hold",   B_RX,   1'b1);
    exp_bit(s0 + 1, "down_data",      B_DATA, 1'b0);
    exp_bit(s0 + 2, "down_rx_off",    B_RX,   1'b0);
    exp_bit(s0 + 2, "down_term_hold", B_TERM, 1'b1);
    exp_bit(s0 + 2, "down_ready_lo",  B_RDY,  1'b0);
    exp_bit(s0 + 2, "down_boost",     B_BOOST, 1'b0);
    exp_bit(s0 + 3, "down_term_off",  B_TERM, 1'b0);
    exp_bit(s0 + 3, "down_cm_off",    B_CM,   1'b0);
    exp_bit(s0 + 3, "down_busy",      B_BUSY, 1'b1);
    exp_bit(s0 + 3, "down_ready_hi",  B_RDY,  1'b1);
    exp_bit(s0 + 4, "down_busy_off",  B_BUSY, 1'b0);
    exp_cfg(s0 + 3, "down_cfg",       15'h7FFF);
    exp_cfg(s0 + 6, "down_cfg_late",  15'h7FFF);
    goto(s0 + 4);
    ctl.stop = 1'b0;
    goto(s0 + 7);

    // start and stop together in OFF: stay in OFF
    c = cyc;
    ctl.start = 1'b1; ctl.stop = 1'b1;
    exp_bit(c + 1, "ss_ready", B_RDY,  1'b1);
    exp_bit(c + 2, "ss_term",  B_TERM, 1'b0);
    exp_bit(c + 2, "ss_busy",  B_BUSY, 1'b0);
    goto(c + 3);
    ctl.start = 1'b0; ctl.stop = 1'b0;

    // rst during RXON
    c = cyc; e0 = c + 1;
    ctl.start = 1'b1;
    exp_bit(e0 + 20, "rxon_rx", B_RX, 1'b1);
    tick();
    ctl.start = 1'b0;
    goto(e0 + 20);
    rst = 1'b1;
    push(e0 + 21, "rst_rxon", FULL, RST_VEC);
    tick();
    rst = 1'b0;
    exp_bit(e0 + 24, "rst_stays_off", B_TERM, 1'b0);
    exp_bit(e0 + 24, "rst_not_busy",  B_BUSY, 1'b0);
    goto(e0 + 24);

    // Restart from OFF; a write while cfg_ready is low is dropped
    c = cyc; e0 = c + 1;
    ctl.start = 1'b1;
    exp_bit(e0 + 1,  "re_term", B_TERM, 1'b1);
    exp_bit(e0 + 16, "re_rx_early", B_RX, 1'b0);
    exp_bit(e0 + 17, "re_rx_on", B_RX, 1'b1);
    exp_cfg(e0 + 4,  "drop_cfg",  15'h4000);
    exp_cfg(e0 + 17, "drop_cfg2", 15'h4000);
    tick();
    ctl.start = 1'b0;
    goto(e0 + 2);
    ctl.cfg_wr = 1'b1; ctl.cfg_wdata = 15'h1111;
    tick();
    ctl.cfg_wr = 1'b0;
    goto(e0 + 18);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clps_link_ctrl.md
# clps_link_ctrl

Power-up sequencer and configuration scheduler for one CLPS transmitter/receiver pad pair. It brings the pads up in a fixed order: termination and common-mode first, then receiver enable, then transmitter enable. It holds the pad configuration in shadow registers and applies run-time configuration changes only while the transmit data is muted, so the link never drives a partially reconfigured pad. It sits between the chip control/register logic and the `CLPS_Tx`/`CLPS_Rx` pad instances.

## Interface
Parameters:
- `TERM_WAIT`, 16: cycles spent in TERM before the receiver is enabled (≥1).
- `RX_WAIT`, 32: cycles spent in RXON before the transmitter is enabled (≥1).
- `GUARD`, 4: mute cycles before and after a configuration apply (≥1).
- `BOOST_CYCLES`, 8: boost pulse length (used only with `CLPS_BOOST_EN`).

Ports:
- `DCLK_1` in 1: system clock. Rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: level. Requests link bring-up while in OFF.
- `stop` in 1: level. Requests power-down from any state except OFF.
- `cfg_wr` in 1: configuration write strobe. Accepted only when `cfg_ready`=1.
- `cfg_wdata` in 15: {DrvStrength[14:12], PEmode[11:10], PEstrength[9:7], PEwidth[6:4], TxInvert[3], RxInvert[2], equalizer[1:0]}.
- `cfg_ready` out 1: high in OFF and ACTIVE when no write is pending.
- `tx_data` in 1: serial payload toward the pad.
- `DataIn` out 1: to the pad. `tx_data` in ACTIVE, otherwise 0.
- `TxEn`, `RxEn`, `termEn`, `setCM`, `boost` out 1 each: pad controls.
- `DrvStrength` out 3, `PEmode` out 2, `PEstrength` out 3, `PEwidth` out 3, `TxInvert` out 1, `RxInvert` out 1, `equalizer` out 2: applied configuration.
- `link_up` out 1: high only in ACTIVE.
- `busy` out 1: high in every state except OFF and ACTIVE.

## Operation
- All outputs are registered.
- Reset values: state OFF; all pad enables 0; `DataIn`=0; `boost`=0; `link_up`=0; `busy`=0; `cfg_ready`=1; applied and shadow configuration both = 15'h4000 (DrvStrength=3'b100, all other fields 0).

State machine:
- OFF
  - `start`=1 → TERM; load the wait counter with `TERM_WAIT`-1.
  - A `cfg_wr` in OFF writes the shadow and the applied configuration directly. No mute is needed.
- TERM
  - Outputs: `termEn`=1, `setCM`=1.
  - When the counter reaches 0 → RXON; load `RX_WAIT`-1.
- RXON
  - Outputs: TERM outputs plus `RxEn`=1.
  - When the counter reaches 0 → TXON.
- TXON: one cycle. `TxEn`=1 → ACTIVE.
- ACTIVE
  - All enables are high and `DataIn`=`tx_data`.
  - A `cfg_wr` latches the shadow, drops `cfg_ready`, and moves to MUTE_PRE with the counter loaded with `GUARD`-1.
- MUTE_PRE
  - `DataIn`=0.
  - When the counter reaches 0 → APPLY.
- APPLY: one cycle. Shadow is copied to the applied configuration → MUTE_POST (`GUARD`-1).
- MUTE_POST
  - `DataIn`=0.
  - When the counter reaches 0 → ACTIVE; `cfg_ready` returns to 1.
- DOWN
  - Entered from any non-OFF state when `stop`=1.
  - Cycle 1: `TxEn`=0.
  - Cycle 2: `RxEn`=0.
  - Cycle 3: `termEn`=0, `setCM`=0 → OFF.

Rules and boundary conditions:
- `stop` has priority over counter expiry and over `cfg_wr` in the same cycle.
- If `stop` arrives during MUTE_PRE, the pending shadow is discarded and the applied configuration is unchanged.
- If `stop` arrives during APPLY, the copy does not happen.
- `start` and `stop` both high in OFF: stay in OFF.
- `start` is ignored outside OFF.
- `stop` is ignored in DOWN, so the sequence is not restarted.
- `cfg_wr` while `cfg_ready`=0 is dropped silently. Shadow and applied configuration are unchanged.
- `rst` mid-operation returns every output to its reset value on the next edge. There is no staged power-down.
- The wait counter is $clog2(max(TERM_WAIT,RX_WAIT,GUARD,BOOST_CYCLES)+1) bits wide and decrements saturating at 0.

## Timing
- From the `start` sample edge:
  - `termEn` high 1 cycle later.
  - `RxEn` high `TERM_WAIT`+1 cycles later.
  - `TxEn` high `TERM_WAIT`+`RX_WAIT`+1 cycles later.
  - `link_up` high `TERM_WAIT`+`RX_WAIT`+2 cycles later.
- A configuration write in ACTIVE changes the outputs after `GUARD`+1 cycles.
- `link_up` returns after 2·`GUARD`+1 cycles.
- `DataIn` is 0 for exactly 2·`GUARD`+1 cycles.
- `stop`→OFF takes 3 cycles. `busy` is high throughout.
- `DataIn` adds a 1-cycle register delay relative to `tx_data`.

## Configuration
- `CLPS_BOOST_EN` defined:
  - `boost`=1 for `BOOST_CYCLES` cycles starting at TXON.
  - Also `boost`=1 for `BOOST_CYCLES` cycles starting at each APPLY.
  - `boost` is forced to 0 by DOWN or `rst`.
- `CLPS_BOOST_EN` undefined: `boost` is tied to 0 and the boost counter is not built.

## Structure
- Shared package `clps_pkg` holds:
  - The state enum.
  - The `cfg_wdata` field offsets and widths.
  - The reset configuration constant `CLPS_CFG_RST`=15'h4000.
- One sub-module, `clps_wait_cnt`: a loadable down-counter with a `zero` flag, instanced for the state waits and for boost.

## Test plan
- Reset, then `start`=1 with TERM_WAIT=16, RX_WAIT=32: `termEn`@+1, `RxEn`@+17, `TxEn`@+49, `link_up`@+50.
- In ACTIVE, write 15'h7FFF: `DataIn`=0 for 9 cycles; all config outputs go to their maximum values on cycle 5; `cfg_ready` returns after 9 cycles.
- Second `cfg_wr` during MUTE_PRE: dropped. Final applied value equals the first write.
- `stop` during MUTE_PRE: `TxEn`, `RxEn`, `termEn` fall in order over 3 cycles. Applied configuration is still the old value.
- `rst` during RXON: all outputs return to reset values on the next edge; the state is OFF.
- `CLPS_BOOST_EN` defined: `boost` high for 8 cycles from TXON, and again from APPLY. With the macro undefined, `boost` stays 0.
